// File: rtl/div_seq.sv
// div_seq: multi-cycle restoring divider, one quotient bit per clock.
// Optional signed mode is enabled by defining DIV_SEQ_SIGNED_EN.
module div_seq #(
    parameter int WIDTH = 16,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef DIV_SEQ_SIGNED_EN
    input  logic             Signed,
`endif
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Quotient,
    output logic [WIDTH-1:0] Remainder,
    output logic             DivZero
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIN
    } state_e;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);
    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             dz_q, dz_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;

    logic             sgn;
    logic             idle_or_fin;
    logic             accept;
    logic             b_zero;
    logic             last;
    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH-1:0] r_sh;
    logic [WIDTH-1:0] q_sh;
    logic [WIDTH:0]   t;
    logic [WIDTH-1:0] r_it;
    logic [WIDTH-1:0] q_it;
    logic [WIDTH-1:0] q_fix;
    logic [WIDTH-1:0] r_fix;

`ifdef DIV_SEQ_SIGNED_EN
    assign sgn = Signed;
`else
    assign sgn = 1'b0;
`endif

    assign idle_or_fin = (state_q == S_IDLE) || (state_q == S_FIN);
    assign accept      = Start && idle_or_fin;
    assign b_zero      = (B == '0);
    assign last        = (state_q == S_RUN) && (cnt_q == LAST);

    // Operand magnitudes taken on entry; identity in unsigned mode.
    always_comb begin
        a_mag = A;
        b_mag = B;
        if (sgn && A[WIDTH-1]) a_mag = ~A + ONE;
        if (sgn && B[WIDTH-1]) b_mag = ~B + ONE;
    end

    // One restoring iteration: shift, trial subtract, keep or restore.
    always_comb begin
        r_sh = {r_q[WIDTH-2:0], q_q[WIDTH-1]};
        q_sh = {q_q[WIDTH-2:0], 1'b0};
        t    = {1'b0, r_sh} - {1'b0, d_q};
        if (!t[WIDTH]) begin
            r_it = t[WIDTH-1:0];
            q_it = q_sh | ONE;
        end else begin
            r_it = r_sh;
            q_it = q_sh;
        end
    end

    // Sign correction applied on the edge that enters FIN.
    always_comb begin
        q_fix = qneg_q ? (~q_it + ONE) : q_it;
        r_fix = rneg_q ? (~r_it + ONE) : r_it;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (Start) state_d = b_zero ? S_FIN : S_RUN;
            end
            S_RUN: begin
                if (cnt_q == LAST) state_d = S_FIN;
            end
            S_FIN: begin
                if (Start) state_d = b_zero ? S_FIN : S_RUN;
                else       state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Status outputs decoded from the state.
    always_comb begin
        Busy = 1'b0;
        Done = 1'b0;
        unique case (state_q)
            S_RUN:   Busy = 1'b1;
            S_FIN:   Done = 1'b1;
            default: ;
        endcase
    end

    // Datapath next-state: load on accept, iterate in RUN, publish on last.
    always_comb begin
        q_d    = q_q;
        r_d    = r_q;
        d_d    = d_q;
        cnt_d  = cnt_q;
        quot_d = quot_q;
        rem_d  = rem_q;
        dz_d   = dz_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        if (accept) begin
            q_d    = a_mag;
            r_d    = '0;
            d_d    = b_mag;
            cnt_d  = '0;
            qneg_d = sgn && (A[WIDTH-1] ^ B[WIDTH-1]);
            rneg_d = sgn && A[WIDTH-1];
            if (b_zero) begin
                quot_d = '1;
                rem_d  = A;
                dz_d   = 1'b1;
            end else begin
                quot_d = '0;
                rem_d  = '0;
                dz_d   = 1'b0;
            end
        end else if (state_q == S_RUN) begin
            q_d   = q_it;
            r_d   = r_it;
            cnt_d = cnt_q + CNT_W'(1);
            if (last) begin
                quot_d = q_fix;
                rem_d  = r_fix;
            end
        end
    end

    // Datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            q_q    <= '0;
            r_q    <= '0;
            d_q    <= '0;
            cnt_q  <= '0;
            quot_q <= '0;
            rem_q  <= '0;
            dz_q   <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
        end else begin
            q_q    <= q_d;
            r_q    <= r_d;
            d_q    <= d_d;
            cnt_q  <= cnt_d;
            quot_q <= quot_d;
            rem_q  <= rem_d;
            dz_q   <= dz_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
        end
    end

    assign Quotient  = quot_q;
    assign Remainder = rem_q;
    assign DivZero   = dz_q;

endmodule

// File: tb/tb_div_seq.sv
// tb_div_seq: directed and random checks of div_seq against
// an arithmetic reference model.
module tb_div_seq;

`ifdef DIV_SEQ_SIGNED_EN
    localparam bit SGN_EN = 1'b1;
`else
    localparam bit SGN_EN = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        Start;
    logic [15:0] A;
    logic [15:0] B;
`ifdef DIV_SEQ_SIGNED_EN
    logic        Signed;
`endif
    logic        Busy;
    logic        Done;
    logic [15:0] Quotient;
    logic [15:0] Remainder;
    logic        DivZero;

    int n_chk = 0;
    int n_err = 0;

    div_seq #(.WIDTH(16), .CNT_W(5)) dut (
        .clk      (clk),
        .rst      (rst),
        .Start    (Start),
        .A        (A),
        .B        (B),
`ifdef DIV_SEQ_SIGNED_EN
        .Signed   (Signed),
`endif
        .Busy     (Busy),
        .Done     (Done),
        .Quotient (Quotient),
        .Remainder(Remainder),
        .DivZero  (DivZero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic void model(input  logic [15:0] a,
                                  input  logic [15:0] b,
                                  input  bit          s,
                                  output logic [15:0] q,
                                  output logic [15:0] r,
                                  output logic        dz);
        int sa;
        int sb;
        dz = 1'b0;
        if (b == 16'h0) begin
            q  = 16'hFFFF;
            r  = a;
            dz = 1'b1;
        end else if (s && SGN_EN) begin
            sa = int'($signed(a));
            sb = int'($signed(b));
            if (a == 16'h8000 && b == 16'hFFFF) begin
                q = 16'h8000;
                r = 16'h0000;
            end else begin
                q = 16'(sa / sb);
                r = 16'(sa % sb);
            end
        end else begin
            q = a / b;
            r = a % b;
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(output int lat, output int bsy);
        lat = 0;
        bsy = 0;
        while (!Done && lat < 40) begin
            if (Busy) bsy++;
            step();
            lat++;
        end
    endtask

    task automatic kick(input logic [15:0] a,
                        input logic [15:0] b,
                        input bit          s);
        A     = a;
        B     = b;
        Start = 1'b1;
`ifdef DIV_SEQ_SIGNED_EN
        Signed = s;
`endif
        step();
        Start = 1'b0;
        A     = 16'($urandom);
        B     = 16'($urandom);
    endtask

    task automatic run_op(input logic [15:0] a,
                          input logic [15:0] b,
                          input bit          s);
        logic [15:0] eq;
        logic [15:0] er;
        logic        edz;
        int          lat;
        int          bsy;
        model(a, b, s, eq, er, edz);
        kick(a, b, s);
        wait_done(lat, bsy);
        chk("lat",  lat, edz ? 0 : 16);
        chk("busy", bsy, edz ? 0 : 16);
        chk("quot", Quotient, eq);
        chk("rem",  Remainder, er);
        chk("dz",   DivZero, edz);
        step();
        chk("pulse", Done, 0);
        chk("hq",    Quotient, eq);
        chk("hr",    Remainder, er);
        chk("hdz",   DivZero, edz);
    endtask

    initial begin
        int lat;
        int bsy;
        int dn;
        logic [15:0] ra;
        logic [15:0] rb;
        bit rs;
        rst   = 1'b1;
        Start = 1'b0;
        A     = '0;
        B     = '0;
`ifdef DIV_SEQ_SIGNED_EN
        Signed = 1'b0;
`endif
        step();
        step();
        rst = 1'b0;
        chk("rst_busy", Busy, 0);
        chk("rst_done", Done, 0);
        chk("rst_q",    Quotient, 0);
        chk("rst_r",    Remainder, 0);
        chk("rst_dz",   DivZero, 0);

        run_op(16'd100, 16'd7, 1'b0);
        run_op(16'hFFFF, 16'd1, 1'b0);
        run_op(16'd3, 16'd10, 1'b0);
        run_op(16'd5, 16'd0, 1'b0);

        kick(16'd100, 16'd7, 1'b0);
        repeat (4) step();
        A     = 16'd9;
        B     = 16'd3;
        Start = 1'b1;
        step();
        Start = 1'b0;
        wait_done(lat, bsy);
        chk("ign_lat", lat, 11);
        chk("ign_q",   Quotient, 14);
        chk("ign_r",   Remainder, 2);
        A     = 16'd9;
        B     = 16'd3;
        Start = 1'b1;
        chk("b2b_done", Done, 1);
        step();
        Start = 1'b0;
        chk("b2b_busy", Busy, 1);
        wait_done(lat, bsy);
        chk("b2b_lat", lat, 16);
        chk("b2b_q",   Quotient, 3);
        chk("b2b_r",   Remainder, 0);
        step();

        kick(16'd100, 16'd7, 1'b0);
        repeat (7) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        dn  = 0;
        for (int i = 0; i < 20; i++) begin
            if (Done) dn++;
            step();
        end
        chk("ab_done", dn, 0);
        chk("ab_busy", Busy, 0);
        chk("ab_q",    Quotient, 0);
        chk("ab_r",    Remainder, 0);
        chk("ab_dz",   DivZero, 0);

        if (SGN_EN) begin
            run_op(16'hFFF9, 16'd2, 1'b1);
            run_op(16'h8000, 16'hFFFF, 1'b1);
            run_op(16'h8000, 16'd0, 1'b1);
        end

        for (int i = 0; i < 40; i++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            ra  = 16'($urandom);
            if (sel == 0)     rb = 16'h0;
            else if (sel < 4) rb = 16'($urandom_range(1, 15));
            else              rb = 16'($urandom);
            rs = SGN_EN ? 1'($urandom_range(0, 1)) : 1'b0;
            run_op(ra, rb, rs);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multi-cycle iterative restoring divider for the 16-bit CPU datapath.
- Consumes the subtract-and-test-borrow result each cycle: the same A−B / less-than operation the ALU already performs.
- Issued by the control unit for DIV/REM instructions.
- Control holds the pipeline while Busy=1 and writes Quotient or Remainder to the register file on Done.

Parameters:
- WIDTH, 16: operand, quotient and remainder width in bits.
- CNT_W, 5: iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  synchronous, active-high reset.
- Start  in  1  request; sampled on a rising edge while the unit is idle.
- A  in  WIDTH  dividend; sampled only on the edge that accepts Start.
- B  in  WIDTH  divisor; sampled only on the edge that accepts Start.
- Busy  out  1  high while a division is in progress.
- Done  out  1  one-cycle pulse when results are valid.
- Quotient  out  WIDTH  A/B, truncated.
- Remainder  out  WIDTH  A mod B.
- DivZero  out  1  set when B==0 for the completed operation.

Behaviour:
- Reset: rst=1 on a rising edge forces state IDLE.
  - Busy=0, Done=0, Quotient=0, Remainder=0, DivZero=0, counter=0.
  - Reset mid-operation aborts it with no Done pulse.
  - rst has priority over Start.
- States: IDLE, RUN, FIN.
- IDLE or FIN with Start=1 (edge E0):
  - Latch A into the dividend/quotient shift register and B into the divisor register.
  - Clear the partial remainder and counter; clear DivZero.
  - Go to RUN with Busy=1.
  - If B==0, go to FIN instead: Quotient=all ones, Remainder=A, DivZero=1.
- FIN with Start=0: go to IDLE. FIN lasts exactly one cycle, so Done is a one-cycle pulse.
- RUN: one iteration per edge, E1..E_WIDTH.
  - Shift: R' = {R[WIDTH-2:0], Q[WIDTH-1]} and Q' = Q<<1.
  - Compute T = R' − D at WIDTH+1 bits.
  - If T has no borrow (R' ≥ D): R=T[WIDTH-1:0] and Q[0]=1.
  - Otherwise: R=R' and Q[0]=0.
  - Increment the counter. On the edge where counter==WIDTH−1, go to FIN.
- Timing:
  - Done=1 and Busy=0 in the cycle after edge E_WIDTH, i.e. Done is high during cycle WIDTH+1 after the accepting edge.
  - Divide-by-zero: Done is high in the cycle after E0.
- Output holding: Quotient, Remainder and DivZero hold their values from FIN until the next accepted Start or rst.
- Busy handling: Start while Busy=1 is ignored; A and B are not re-sampled.
- Back-to-back: Start asserted in the FIN cycle is accepted. Done still pulses for the completed result and Busy goes high the next cycle.
- Arithmetic is unsigned unless the optional feature is enabled. No overflow is possible in unsigned mode.

Optional Feature:
- Macro: DIV_SEQ_SIGNED_EN.
- Enabled:
  - Adds input port Signed (1 bit), sampled together with Start.
  - When Signed=1, operands are magnitude-converted on entry and the iterations run on the magnitudes.
  - In FIN, the quotient is negated if sign(A)≠sign(B), and the remainder takes the sign of A (truncation toward zero).
  - Correction happens inside the FIN transition, so latency is unchanged.
  - Overflow case: A=most-negative, B=−1 gives Quotient=A, Remainder=0, DivZero=0.
  - Divide-by-zero in signed mode gives the same results as unsigned mode.
- Disabled: no Signed port; unsigned only.

Test Plan:
- After rst: Busy=0, Done=0, Quotient=0, Remainder=0, DivZero=0.
- A=100, B=7, Start for one cycle:
  - Busy=1 for 16 cycles.
  - Done pulses exactly one cycle at cycle 17 with Quotient=14, Remainder=2, DivZero=0.
  - Outputs are held afterwards.
- A=0xFFFF, B=1: Quotient=0xFFFF, Remainder=0.
- A=3, B=10: Quotient=0, Remainder=3.
- A=5, B=0: Done in the cycle after the accepting edge; Quotient=0xFFFF, Remainder=5, DivZero=1.
- Ignored restart: start 100/7, then Start with A=9, B=3 at cycle 5 → ignored; result is still 14/2.
  - Back-to-back: Start with 9/3 in the Done cycle → accepted; Quotient=3, Remainder=0 at 17 cycles later.
- Reset abort: rst at cycle 8 of a run → no Done pulse, all outputs 0.
- Signed build:
  - Signed=1, A=0xFFF9 (−7), B=2: Quotient=0xFFFD (−3), Remainder=0xFFFF (−1).
  - Signed=1, A=0x8000, B=0xFFFF: Quotient=0x8000, Remainder=0.
